// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and counter sizing for the PISO register
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_e;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_reg.sv
// piso_reg: parallel-in serial-out shift register with valid/ready load and registered serial valid/last
module piso_reg
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] par_data_i,
    input  logic             par_valid_i,
    output logic             par_ready_o,
    output logic             ser_data_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    output logic             busy_o
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_reg: WIDTH must be at least 2");
    end

    piso_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             ser_data_q, ser_valid_q, ser_last_q;
    logic             accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign par_ready_o = (state_q == IDLE) || (state_q == SHIFT && cnt_q == LAST);
    assign accept      = par_valid_i && par_ready_o;
    assign busy_o      = (state_q == SHIFT);
    assign ser_data_o  = ser_data_q;
    assign ser_valid_o = ser_valid_q;
    assign ser_last_o  = ser_last_q;

    // load on accept, otherwise advance one bit or fall back to IDLE after the last bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sh_d    = par_data_i;
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                sh_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                sh_d  = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
            end
        end
    end

    // state plus serial outputs precomputed from next state so the consumer sees clean flops
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ser_data_q  <= (state_d == SHIFT) && head(sh_d);
            ser_valid_q <= (state_d == SHIFT);
            ser_last_q  <= (state_d == SHIFT) && (cnt_d == LAST);
        end
    end

endmodule

// File: tb/tb_piso_reg.sv
// tb_piso_reg: queue-model checked bench for piso_reg in both bit orders
module tb_piso_reg;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic [W-1:0] par_data = '0;
    logic         par_valid = 1'b0;
    logic         rdy_m, dat_m, val_m, lst_m, bsy_m;
    logic         rdy_l, dat_l, val_l, lst_l, bsy_l;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    piso_reg #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .arst_n(arst_n), .par_data_i(par_data), .par_valid_i(par_valid),
        .par_ready_o(rdy_m), .ser_data_o(dat_m), .ser_valid_o(val_m), .ser_last_o(lst_m), .busy_o(bsy_m)
    );

    piso_reg #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .arst_n(arst_n), .par_data_i(par_data), .par_valid_i(par_valid),
        .par_ready_o(rdy_l), .ser_data_o(dat_l), .ser_valid_o(val_l), .ser_last_o(lst_l), .busy_o(bsy_l)
    );

    // model: queue of {last,data} bits still owed on the wire; front entry is the bit shown this cycle
    logic [1:0]   qm[$];
    logic [1:0]   ql[$];
    logic [W-1:0] sent[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return qm.size() <= 1;
    endfunction

    task automatic push_word(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            qm.push_back({i == W - 1, d[W-1-i]});
            ql.push_back({i == W - 1, d[i]});
        end
    endtask

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            qm.delete();
            ql.delete();
            sent.delete();
        end else begin
            bit acc;
            acc = par_valid && m_ready();
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                push_word(par_data);
                sent.push_back(par_data);
            end
        end
    end

    always @(negedge clk) begin
        if (arst_n) begin
            logic [1:0] fm, fl;
            fm = (qm.size() > 0) ? qm[0] : 2'b00;
            fl = (ql.size() > 0) ? ql[0] : 2'b00;
            chk("ready_m", 32'(rdy_m), 32'(m_ready()));
            chk("valid_m", 32'(val_m), 32'(qm.size() > 0));
            chk("last_m",  32'(lst_m), 32'(fm[1]));
            chk("data_m",  32'(dat_m), 32'(fm[0]));
            chk("busy_m",  32'(bsy_m), 32'(qm.size() > 0));
            chk("ready_l", 32'(rdy_l), 32'(m_ready()));
            chk("valid_l", 32'(val_l), 32'(ql.size() > 0));
            chk("last_l",  32'(lst_l), 32'(fl[1]));
            chk("data_l",  32'(dat_l), 32'(fl[0]));
            chk("busy_l",  32'(bsy_l), 32'(ql.size() > 0));
        end
    end

    // stream capture and loopback deserialisers fed straight from the serial outputs
    logic [31:0]  cap_m = '0, cap_l = '0;
    logic [W-1:0] sipo_m = '0, sipo_l = '0;
    int ncap = 0, first_c = -1, last_c = 0, cyc = 0, words_rx = 0;

    always @(negedge clk) begin
        cyc++;
        if (arst_n && val_m) begin
            cap_m = {cap_m[30:0], dat_m};
            cap_l = {cap_l[30:0], dat_l};
            ncap++;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            sipo_m = {sipo_m[W-2:0], dat_m};
            sipo_l = {dat_l, sipo_l[W-1:1]};
            if (lst_m) begin
                logic [W-1:0] exp;
                exp = (sent.size() > 0) ? sent.pop_front() : 'x;
                chk("loop_m", 32'(sipo_m), 32'(exp));
                chk("loop_l", 32'(sipo_l), 32'(exp));
                words_rx++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        cap_m = '0;
        cap_l = '0;
        ncap = 0;
        first_c = -1;
    endtask

    task automatic send(input logic [W-1:0] d);
        int n;
        n = 0;
        par_data = d;
        par_valid = 1'b1;
        while (!m_ready() && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no ready expected ready within 100 cycles");
        end
        tick();
        par_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'({rdy_m, rdy_l}), 32'b11);
        chk({tag, "_valid"}, 32'({val_m, val_l}), 32'b00);
        chk({tag, "_last"},  32'({lst_m, lst_l}), 32'b00);
        chk({tag, "_data"},  32'({dat_m, dat_l}), 32'b00);
        chk({tag, "_busy"},  32'({bsy_m, bsy_l}), 32'b00);
    endtask

    initial begin
        int st, rx0;
        #3;
        chk_reset_outputs("rst");
        #4 arst_n = 1'b1;
        tick();

        clr();
        send(8'hC1);
        tick(10);
        chk("c1_msb", cap_m, 32'h0000_00C1);
        chk("c1_lsb", cap_l, 32'h0000_0083);
        chk("c1_bits", 32'(ncap), 32'd8);
        chk("c1_span", 32'(last_c - first_c + 1), 32'd8);

        clr();
        send(8'hC1);
        send(8'h3C);
        tick(10);
        chk("b2b_msb", cap_m, 32'h0000_C13C);
        chk("b2b_lsb", cap_l, 32'h0000_833C);
        chk("b2b_bits", 32'(ncap), 32'd16);
        chk("b2b_span", 32'(last_c - first_c + 1), 32'd16);

        clr();
        send(8'h55);
        tick(2);
        par_data = 8'hAA;
        par_valid = 1'b1;
        st = 0;
        while (!rdy_m && st < 20) begin
            tick();
            st++;
        end
        chk("stall_cycles", 32'(st), 32'd5);
        tick();
        par_valid = 1'b0;
        tick(10);
        chk("stall_msb", cap_m, 32'h0000_55AA);
        chk("stall_lsb", cap_l, 32'h0000_AA55);
        chk("stall_span", 32'(last_c - first_c + 1), 32'd16);

        clr();
        send(8'hF0);
        tick(2);
        #2 arst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        #4 arst_n = 1'b1;
        tick();
        clr();
        send(8'hFF);
        tick(10);
        chk("ff_msb", cap_m, 32'h0000_00FF);
        chk("ff_lsb", cap_l, 32'h0000_00FF);
        chk("ff_bits", 32'(ncap), 32'd8);

        rx0 = words_rx;
        for (int i = 0; i < 200; i++) begin
            send(W'($urandom));
            tick($urandom_range(0, 3));
        end
        tick(12);
        chk("loop_count", 32'(words_rx - rx0), 32'd200);
        chk("loop_pending", 32'(sent.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
